// File: rtl/formation_controller.sv
// formation_controller
//   Enemy-formation sequencer. Keeps a single formation origin and marches
//   it right/left across the playfield, descending and speeding up at each
//   wall. Wall detection only considers columns/rows that still hold a live
//   enemy. A round-robin search over the live mask picks the next shooter.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   restart           synchronous clear, same effect as reset
//   enable            game running; counters and state hold while low
//   alive             live mask, index = row*COLS + col
//   origin_x/_y       formation origin (enemy (0,0) top-left)
//   speed             speed level, march step = 1 + speed
//   fire              one-cycle shot request
//   shooter_id/_x/_y  selected enemy index and muzzle coordinates
//   invaded           sticky: formation bottom reached Y_LIMIT
//   all_dead          combinational, no live enemy left
module formation_controller #(
  parameter int ROWS      = 4,
  parameter int COLS      = 10,
  parameter int COL_PITCH = 30,
  parameter int ROW_PITCH = 30,
  parameter int STAGGER   = 10,
  parameter int X0        = 150,
  parameter int Y0        = 40,
  parameter int X_MIN     = 120,
  parameter int X_MAX     = 790,
  parameter int DY        = 50,
  parameter int Y_LIMIT   = 440,
  parameter int SPRITE_W  = 20,
  parameter int SPRITE_H  = 16,
  parameter int SPEED_MAX = 15,
  parameter int TICK_DIV  = 2097152,
  parameter int FIRE_DIV  = 10000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] alive,
  output logic [10:0]          origin_x,
  output logic [10:0]          origin_y,
  output logic [3:0]           speed,
  output logic                 fire,
  output logic [6:0]           shooter_id,
  output logic [10:0]          shooter_x,
  output logic [10:0]          shooter_y,
  output logic                 invaded,
  output logic                 all_dead
);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {MOVE_R, MOVE_L, DESC_TO_L, DESC_TO_R} state_t;

  state_t      state, state_n;
  logic [10:0] ox_n, oy_n;
  logic [3:0]  spd_n;
  logic        clr;
  logic [31:0] move_cnt, fire_cnt;
  logic        move_tick, fire_tick;
  logic [6:0]  ptr;

  assign clr       = reset | restart;
  assign all_dead  = ~|alive;
  assign move_tick = enable & ~restart & (move_cnt == 32'(TICK_DIV - 1));
  assign fire_tick = enable & ~restart & (fire_cnt == 32'(FIRE_DIV - 1));

  // ---------------- extents of the live part of the formation
  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;
  logic [10:0]     minc, maxc, maxr;
  logic [10:0]     left_edge, right_edge, bottom, step;

  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive[r*COLS+c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
    minc = '0;
    maxc = '0;
    maxr = '0;
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) minc = 11'(c);
    for (int c = 0; c < COLS; c++)      if (col_any[c]) maxc = 11'(c);
    for (int r = 0; r < ROWS; r++)      if (row_any[r]) maxr = 11'(r);
  end

  assign left_edge  = origin_x + minc * 11'(COL_PITCH);
  assign right_edge = origin_x + maxc * 11'(COL_PITCH) + 11'(STAGGER) + 11'(SPRITE_W);
  assign bottom     = origin_y + maxr * 11'(ROW_PITCH) + 11'(SPRITE_H);
  assign step       = 11'(speed) + 11'd1;

  // ---------------- per-enemy muzzle offsets relative to the origin
  logic [10:0] ofs_x [N];
  logic [10:0] ofs_y [N];
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign ofs_x[r*COLS+c] = 11'(c*COL_PITCH + ((r % 2) == 1 ? STAGGER : 0) + SPRITE_W/2);
      assign ofs_y[r*COLS+c] = 11'(r*ROW_PITCH + SPRITE_H);
    end
  end

  // ---------------- round-robin search: first live index after ptr, wrapping
  logic          found;
  logic [6:0]    sel;
  logic [7:0]    probe;
  logic [N-1:0]  alive_sh;
  logic [IW-1:0] sel_i;

  always_comb begin
    found    = 1'b0;
    sel      = '0;
    probe    = '0;
    alive_sh = '0;
    for (int k = 1; k <= N; k++) begin
      probe = 8'(ptr) + 8'(k);
      if (probe >= 8'(N)) probe = probe - 8'(N);
      alive_sh = alive >> probe;
      if (!found && alive_sh[0]) begin
        found = 1'b1;
        sel   = 7'(probe);
      end
    end
  end

  assign sel_i = sel[IW-1:0];

  // ---------------- march FSM, next state
  always_comb begin
    state_n = state;
    ox_n    = origin_x;
    oy_n    = origin_y;
    spd_n   = speed;
    if (move_tick && !all_dead && !invaded) begin
      case (state)
        MOVE_R:
          if (right_edge + step > 11'(X_MAX)) state_n = DESC_TO_L;
          else                                 ox_n    = origin_x + step;
        MOVE_L:
          if (left_edge < 11'(X_MIN) + step)  state_n = DESC_TO_R;
          else                                 ox_n    = origin_x - step;
        DESC_TO_L, DESC_TO_R: begin
          oy_n    = origin_y + 11'(DY);
          spd_n   = (speed < 4'(SPEED_MAX)) ? speed + 4'd1 : 4'(SPEED_MAX);
          state_n = (state == DESC_TO_L) ? MOVE_L : MOVE_R;
        end
        default: state_n = MOVE_R;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= MOVE_R;
      origin_x   <= 11'(X0);
      origin_y   <= 11'(Y0);
      speed      <= '0;
      move_cnt   <= '0;
      fire_cnt   <= '0;
      ptr        <= 7'(N - 1);
      fire       <= 1'b0;
      shooter_id <= '0;
      shooter_x  <= '0;
      shooter_y  <= '0;
      invaded    <= 1'b0;
    end else begin
      state    <= state_n;
      origin_x <= ox_n;
      origin_y <= oy_n;
      speed    <= spd_n;
      if (enable) begin
        move_cnt <= move_tick ? '0 : move_cnt + 32'd1;
        fire_cnt <= fire_tick ? '0 : fire_cnt + 32'd1;
      end
      fire <= 1'b0;
      // Muzzle uses the pre-tick origin even if the formation moves this cycle.
      if (fire_tick && !all_dead && !invaded && found) begin
        fire       <= 1'b1;
        shooter_id <= sel;
        ptr        <= sel;
        shooter_x  <= origin_x + ofs_x[sel_i];
        shooter_y  <= origin_y + ofs_y[sel_i];
      end
      if (!all_dead && bottom >= 11'(Y_LIMIT)) invaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_formation_controller.sv
// Randomized bench for formation_controller with a behavioural reference
// model (origin/speed/direction bookkeeping over the enemy grid) plus a few
// directed scenarios with hand-derived constants.
module tb_formation_controller;
  localparam int ROWS = 2, COLS = 3, N = 6;
  localparam int TD = 4, FD = 8, YL = 150;

  logic        clk = 1'b0, reset = 1'b1, restart = 1'b0, enable = 1'b1;
  logic [5:0]  alive = 6'b111111;
  logic [10:0] origin_x, origin_y, shooter_x, shooter_y;
  logic [3:0]  speed;
  logic        fire, invaded, all_dead;
  logic [6:0]  shooter_id;

  formation_controller #(
    .ROWS(ROWS), .COLS(COLS), .COL_PITCH(30), .ROW_PITCH(30), .STAGGER(10),
    .X0(100), .Y0(40), .X_MIN(50), .X_MAX(200), .DY(50), .Y_LIMIT(YL),
    .SPRITE_W(20), .SPRITE_H(16), .SPEED_MAX(15), .TICK_DIV(TD), .FIRE_DIV(FD)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .enable(enable), .alive(alive),
    .origin_x(origin_x), .origin_y(origin_y), .speed(speed), .fire(fire),
    .shooter_id(shooter_id), .shooter_x(shooter_x), .shooter_y(shooter_y),
    .invaded(invaded), .all_dead(all_dead)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model
  int m_ox = 100, m_oy = 40, m_spd = 0, m_dir = 1, m_desc = 0, m_inv = 0;
  int m_fire = 0, m_id = 0, m_sx = 0, m_sy = 0, m_ptr = N - 1;
  int m_mcnt = 0, m_fcnt = 0;
  int fire_seen = 0;

  task automatic model_step();
    int mt, ft, dead, minc, maxc, maxr, left, right, bot, st, px, py, j;
    if (reset || restart) begin
      m_ox = 100; m_oy = 40; m_spd = 0; m_dir = 1; m_desc = 0; m_inv = 0;
      m_fire = 0; m_id = 0; m_sx = 0; m_sy = 0; m_ptr = N - 1;
      m_mcnt = 0; m_fcnt = 0;
      return;
    end
    mt = (enable && m_mcnt == TD - 1);
    ft = (enable && m_fcnt == FD - 1);
    if (enable) begin
      m_mcnt = (m_mcnt + 1) % TD;
      m_fcnt = (m_fcnt + 1) % FD;
    end
    dead = (alive == 6'd0);
    minc = COLS; maxc = 0; maxr = 0;
    for (int i = 0; i < N; i++)
      if (alive[i]) begin
        if (i % COLS < minc) minc = i % COLS;
        if (i % COLS > maxc) maxc = i % COLS;
        if (i / COLS > maxr) maxr = i / COLS;
      end
    if (minc == COLS) minc = 0;
    left  = (m_ox + minc * 30) & 2047;
    right = (m_ox + maxc * 30 + 10 + 20) & 2047;
    bot   = (m_oy + maxr * 30 + 16) & 2047;
    st    = 1 + m_spd;
    px = m_ox; py = m_oy;
    if (mt && !dead && !m_inv) begin
      if (m_desc) begin
        m_oy   = (m_oy + 50) & 2047;
        m_spd  = (m_spd < 15) ? m_spd + 1 : 15;
        m_dir  = !m_dir;
        m_desc = 0;
      end else if (m_dir) begin
        if (((right + st) & 2047) > 200) m_desc = 1;
        else m_ox = (m_ox + st) & 2047;
      end else begin
        if (left < 50 + st) m_desc = 1;
        else m_ox = (m_ox - st) & 2047;
      end
    end
    m_fire = 0;
    if (ft && !dead && !m_inv)
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (alive[j]) begin
          m_fire = 1; m_id = j; m_ptr = j;
          m_sx = (px + (j % COLS) * 30 + (((j / COLS) % 2) ? 10 : 0) + 10) & 2047;
          m_sy = (py + (j / COLS) * 30 + 16) & 2047;
          break;
        end
      end
    if (!dead && bot >= YL) m_inv = 1;
  endtask

  // One clock: model advances on the edge, outputs compared half a cycle later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("origin_x", origin_x, m_ox);
    chk("origin_y", origin_y, m_oy);
    chk("speed", speed, m_spd);
    chk("fire", fire, m_fire);
    chk("shooter_id", shooter_id, m_id);
    chk("shooter_x", shooter_x, m_sx);
    chk("shooter_y", shooter_y, m_sy);
    chk("invaded", invaded, m_inv);
    chk("all_dead", all_dead, alive == 6'd0);
    if (fire) fire_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_restart();
    restart = 1'b1; cyc(); restart = 1'b0;
  endtask

  logic [5:0] pats [5] = '{6'b111111, 6'b011011, 6'b100101, 6'b000000, 6'b110000};
  int ids [$];
  int sx0, sy0;

  initial begin
    // reset state and tick phase across an enable gap
    @(negedge clk);
    run(2);
    reset = 1'b0;
    chk("rst_ox", origin_x, 100);
    chk("rst_oy", origin_y, 40);
    chk("rst_speed", speed, 0);
    chk("rst_fire", fire, 0);
    chk("rst_invaded", invaded, 0);
    run(2);
    enable = 1'b0; run(10); enable = 1'b1;
    run(1);
    chk("phase_hold_ox", origin_x, 100);
    run(1);
    chk("tick1_ox", origin_x, 101);
    run(36);
    chk("tick10_ox", origin_x, 110);
    run(4);
    chk("tick11_ox", origin_x, 110);
    run(4);
    chk("desc_oy", origin_y, 90);
    chk("desc_speed", speed, 1);
    run(4);
    chk("tick13_ox", origin_x, 108);

    // narrowed formation marches further right
    do_restart(); run(40);
    alive = 6'b011011;
    run(120);
    chk("narrow_ox", origin_x, 140);
    chk("narrow_oy", origin_y, 40);

    // round-robin order over a sparse mask
    alive = 6'b100101; do_restart();
    ids.delete();
    for (int i = 0; i < 100 && ids.size() < 4; i++) begin
      cyc();
      if (fire) ids.push_back(int'(shooter_id));
    end
    chk("rr_count", ids.size(), 4);
    if (ids.size() == 4) begin
      chk("rr_id0", ids[0], 0); chk("rr_id1", ids[1], 2);
      chk("rr_id2", ids[2], 5); chk("rr_id3", ids[3], 0);
    end

    // invasion freezes the formation and stops fire
    alive = 6'b111111; do_restart();
    for (int i = 0; i < 400 && !invaded; i++) cyc();
    chk("invade_reached", invaded, 1);
    chk("invade_oy", origin_y, 140);
    sx0 = int'(origin_x); sy0 = int'(origin_y);
    fire_seen = 0;
    run(40);
    chk("invade_sticky", invaded, 1);
    chk("invade_frozen_x", origin_x, sx0);
    chk("invade_frozen_y", origin_y, sy0);
    chk("invade_no_fire", fire_seen, 0);

    // all dead during a descent, then restart
    do_restart(); run(44);
    alive = 6'b000000; fire_seen = 0;
    run(12);
    chk("dead_flag", all_dead, 1);
    chk("dead_frozen_x", origin_x, 110);
    chk("dead_no_fire", fire_seen, 0);
    alive = 6'b111111;
    do_restart();
    chk("restart_ox", origin_x, 100);
    chk("restart_oy", origin_y, 40);
    chk("restart_speed", speed, 0);

    // randomized episodes
    for (int ep = 0; ep < 12; ep++) begin
      alive = (ep % 6 == 5) ? 6'($urandom) : pats[ep % 5];
      do_restart();
      for (int i = 0; i < 250; i++) begin
        enable  = ($urandom % 10) != 0;
        restart = ($urandom % 300) == 0;
        if ($urandom % 40 == 0) alive = 6'($urandom);
        cyc();
      end
      restart = 1'b0;
      enable  = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/formation_controller.md
Name: formation_controller

Overview:
- Parametrised enemy-formation sequencer for the Space Invaders game core; it replaces the fixed 4x10 per-enemy position registers in the top level.
- Tracks one formation origin and marches it left and right, with descents and a speed-up after each descent.
- Edge detection uses only live enemies; the shooter is picked round-robin among live enemies.
- Flags an invasion (formation reached the player line) and an all-dead condition for the game state machine.
- Enemy sprite modules derive their own coordinates from the origin.

Parameters:
ROWS, 4, formation rows (1..8)
COLS, 10, formation columns (1..16)
COL_PITCH, 30, horizontal pixel pitch between columns
ROW_PITCH, 30, vertical pixel pitch between rows
STAGGER, 10, extra x offset applied to odd rows
X0, 150, origin x after reset/restart
Y0, 40, origin y after reset/restart
X_MIN, 120, left playfield bound (pixels)
X_MAX, 790, right playfield bound (pixels)
DY, 50, pixels added to origin_y per descent
Y_LIMIT, 440, invasion line (pixels)
SPRITE_W, 20, enemy sprite width
SPRITE_H, 16, enemy sprite height
SPEED_MAX, 15, saturation value of speed level
TICK_DIV, 2097152, clk cycles per movement tick
FIRE_DIV, 10000000, clk cycles per fire tick

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
restart  in  1  synchronous clear, identical effect to reset
enable  in  1  game running; counters and state hold while low
alive  in  ROWS*COLS  live mask, index = row*COLS+col
origin_x  out  11  formation origin x
origin_y  out  11  formation origin y
speed  out  4  current speed level; step = 1 + speed
fire  out  1  one-cycle shot request
shooter_id  out  7  index of selected shooter
shooter_x  out  11  muzzle x = enemy x + SPRITE_W/2
shooter_y  out  11  muzzle y = enemy y + SPRITE_H
invaded  out  1  sticky: bottom of formation reached Y_LIMIT
all_dead  out  1  combinational ~|alive

Behaviour:
- Enemy position (used by consumers and internally):
  - x = origin_x + col*COL_PITCH + (row odd ? STAGGER : 0)
  - y = origin_y + row*ROW_PITCH
- Reset/restart values: origin_x=X0, origin_y=Y0, speed=0, state=MOVE_R, fire=0, shooter_id=0, shooter_x=0, shooter_y=0, invaded=0. Both counters clear, and the round-robin pointer clears to ROWS*COLS-1.
- Tick counters:
  - Each counts only while enable=1 and restart=0.
  - move_tick is a 1-cycle pulse when the counter reaches TICK_DIV-1; the counter then wraps to 0.
  - fire_tick works the same way with FIRE_DIV.
- Extents (combinational, from alive):
  - minc/maxc = lowest/highest column with any live enemy; maxr = highest row with any live enemy.
  - left_edge = origin_x + minc*COL_PITCH
  - right_edge = origin_x + maxc*COL_PITCH + STAGGER + SPRITE_W
  - bottom = origin_y + maxr*ROW_PITCH + SPRITE_H
  - All arithmetic is 11-bit unsigned.
- FSM states: MOVE_R, MOVE_L, DESC_TO_L, DESC_TO_R. Transitions are evaluated only on move_tick with all_dead=0.
  - MOVE_R: if right_edge + step > X_MAX, go to DESC_TO_L with no x change; else origin_x += step.
  - MOVE_L: if left_edge < X_MIN + step, go to DESC_TO_R with no x change; else origin_x -= step.
  - DESC_TO_L / DESC_TO_R: origin_y += DY, speed = min(speed+1, SPEED_MAX), then go to MOVE_L / MOVE_R.
  - all_dead=1: position, speed and state hold.
- invaded:
  - Set on any cycle with all_dead=0 and bottom >= Y_LIMIT.
  - Cleared only by reset/restart.
  - Once set, movement ticks are ignored (position frozen).
- Fire:
  - On fire_tick with all_dead=0 and invaded=0, search from pointer+1 upward with wrap for the first live index.
  - That index becomes shooter_id and pointer; shooter_x/y are computed from the current (pre-tick) origin.
  - fire=1 for exactly that one cycle, with all three outputs registered together.
  - No live enemy: no pulse, outputs hold.
- A simultaneous move_tick and fire_tick are processed independently in the same cycle; shooter coordinates use the pre-update origin.
- alive may change on any cycle; extents react on the next evaluated tick with no latching.
- A reset/restart asserted mid-march or mid-descent overrides everything in that cycle.

Test Plan:
Common sim params unless stated: ROWS=2, COLS=3, COL_PITCH=30, ROW_PITCH=30, STAGGER=10, SPRITE_W=20, SPRITE_H=16, X0=100, Y0=40, X_MIN=50, X_MAX=200, DY=50, Y_LIMIT=440, TICK_DIV=4, FIRE_DIV=8; alive=6'b111111; enable=1.
1. Reset -> origin=(100,40), speed=0, fire=0, invaded=0; move_tick on every 4th enabled cycle; enable low for 10 cycles -> tick phase resumes unchanged.
2. March right, all alive -> origin_x 101..110 over 10 ticks. Tick 11: no x change, enters DESC_TO_L. Tick 12: origin_y=90, speed=1. Tick 13: origin_x=108.
3. Kill column 2 (alive=6'b011011) at origin_x=110 -> right_edge=170; march continues to origin_x=140 before the descent.
4. Round-robin with alive=6'b100101 -> successive fire pulses give shooter_id 0, 2, 5, 0. For id 5 at origin (100,40): shooter_x=100+60+10+10=180, shooter_y=40+30+16=86.
5. Y_LIMIT=150, force descents -> after origin_y reaches 140 (bottom=186), invaded=1 and stays set; further ticks do not move the formation; fire pulses stop.
6. alive=0 -> all_dead=1, no fire pulses, origin frozen. Assert restart mid-DESC state -> origin=(100,40), state MOVE_R, speed=0 the next cycle.
